ssp_rx_fifo: RTL

Receive FIFO of the SSP block, sitting directly downstream of the serial receive logic. Accepts each assembled 8-bit frame on the receiver's write strobe, buffers up to DEPTH frames, and returns them to the APB side one per read access. Drives the full indication back to the receiver and out as SSPRXINTR.

---
 rtl/ssp_rx_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/ssp_rx_fifo.sv
// rtl/ssp_rx_fifo.sv - SSP receive FIFO; optional RXOVR overflow flag under SSP_RX_FIFO_OVERFLOW_EN
module ssp_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  PSEL,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] RxData,
  input  logic                  write_fifo,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  rx_fifo_full,
  output logic                  rx_fifo_empty,
`ifdef SSP_RX_FIFO_OVERFLOW_EN
  output logic                  RXOVR,
`endif
  output logic                  SSPRXINTR
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  wr_d;
  logic                  rd_d;
  logic                  full;
  logic                  empty;
  logic                  push_req;
  logic                  rd_req;
  logic                  pop_req;
  logic                  push;
  logic                  pop;

  // Flags come straight from the registered occupancy so they never glitch
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  // One request per rising edge of the strobe / read access, however long it is held
  assign push_req = write_fifo && !wr_d;
  assign rd_req   = PSEL && !PWRITE;
  assign pop_req  = rd_req && !rd_d;

  // A push into a full FIFO still fits when a pop frees a slot in the same cycle
  assign pop  = pop_req && !empty;
  assign push = push_req && (!full || pop);

  assign rx_fifo_full  = full;
  assign rx_fifo_empty = empty;
  assign SSPRXINTR     = full;

  // Edge-detect history, pointers, occupancy and read data register
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_d   <= 1'b0;
      rd_d   <= 1'b0;
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      PRDATA <= '0;
    end else begin
      wr_d <= write_fifo;
      rd_d <= rd_req;
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        PRDATA <= mem[rp];
        rp     <= rp + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wp] <= RxData;
    end
  end

`ifdef SSP_RX_FIFO_OVERFLOW_EN
  // Sticky overflow: set when a frame is dropped, cleared by the next successful pop.
  // A drop implies no pop in that cycle, so set and clear never coincide.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      RXOVR <= 1'b0;
    end else if (pop) begin
      RXOVR <= 1'b0;
    end else if (push_req && !push) begin
      RXOVR <= 1'b1;
    end
  end
`endif

endmodule
